// File: rtl/check_node_message_generator.sv
// Check-node message generator: expands a compressed min-sum row result
// (min, second_min, pos, edge signs) into one check-to-variable message per
// edge, emitted serially on a valid/ready handshake. Only sign and magnitude
// bits are manipulated; there is no floating-point arithmetic.
module check_node_message_generator #(
    parameter int DEGREE = 3,
    parameter int WIDTH  = 32,
    parameter int IDXW   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_row_generation,
    input  logic [WIDTH-1:0]  min_in,
    input  logic [WIDTH-1:0]  second_min_in,
    input  logic [IDXW-1:0]   pos_in,
    input  logic [DEGREE-1:0] sign_in,
    input  logic              msg_ready,
    output logic              msg_valid,
    output logic [WIDTH-1:0]  msg_out,
    output logic [IDXW-1:0]   msg_index,
    output logic              busy,
    output logic              done_row_generation
);

    typedef enum logic [1:0] {StIdle, StEmit, StDone} state_e;

    state_e              state_q;
    logic [WIDTH-2:0]    min_q;
    logic [WIDTH-2:0]    second_min_q;
    logic [IDXW-1:0]     pos_q;
    logic [DEGREE-1:0]   sign_q;
    logic                total_sign_q;

    logic [IDXW-1:0]     next_idx;
    logic                last_edge;

    // Message for edge j: the excluded edge (j == pos) takes second_min, all
    // others take min; sign is the product of the other edges' signs. A zero
    // magnitude always leaves as +0.0. A pos outside 0..DEGREE-1 never matches,
    // so every edge then carries min.
    function automatic logic [WIDTH-1:0] edge_msg(
        input logic [IDXW-1:0]   j,
        input logic [WIDTH-2:0]  mn,
        input logic [WIDTH-2:0]  smn,
        input logic [IDXW-1:0]   p,
        input logic [DEGREE-1:0] s,
        input logic              ts
    );
        logic [WIDTH-2:0] mag;
        logic             sg;
        mag = (j == p) ? smn : mn;
        sg  = ts ^ s[j];
        if (mag == '0) begin
            sg = 1'b0;
        end
        return {sg, mag};
    endfunction

    // Edge counter advance and last-edge detect; msg_index doubles as the counter.
    always_comb begin
        next_idx  = msg_index + IDXW'(1);
        last_edge = (msg_index == IDXW'(DEGREE - 1));
    end

    // Row FSM with capture registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q             <= StIdle;
            min_q               <= '0;
            second_min_q        <= '0;
            pos_q               <= '0;
            sign_q              <= '0;
            total_sign_q        <= 1'b0;
            msg_valid           <= 1'b0;
            msg_out             <= '0;
            msg_index           <= '0;
            busy                <= 1'b0;
            done_row_generation <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_row_generation <= 1'b0;
                    if (start_row_generation) begin
                        min_q        <= min_in[WIDTH-2:0];
                        second_min_q <= second_min_in[WIDTH-2:0];
                        pos_q        <= pos_in;
                        sign_q       <= sign_in;
                        total_sign_q <= ^sign_in;
                        // Edge 0 is built straight from the inputs so it is
                        // valid in the cycle right after capture.
                        msg_out      <= edge_msg('0, min_in[WIDTH-2:0],
                                                 second_min_in[WIDTH-2:0],
                                                 pos_in, sign_in, ^sign_in);
                        msg_index    <= '0;
                        msg_valid    <= 1'b1;
                        busy         <= 1'b1;
                        state_q      <= StEmit;
                    end
                end
                StEmit: begin
                    if (msg_valid && msg_ready) begin
                        if (last_edge) begin
                            msg_valid           <= 1'b0;
                            done_row_generation <= 1'b1;
                            state_q             <= StDone;
                        end else begin
                            msg_index <= next_idx;
                            msg_out   <= edge_msg(next_idx, min_q, second_min_q,
                                                  pos_q, sign_q, total_sign_q);
                        end
                    end
                end
                StDone: begin
                    done_row_generation <= 1'b0;
                    busy                <= 1'b0;
                    state_q             <= StIdle;
                end
                default: begin
                    state_q   <= StIdle;
                    msg_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_check_node_message_generator.sv
// Bench for check_node_message_generator: table of row vectors with expected
// messages, a scoreboard queue filled at start and drained on each handshake,
// plus hand sequences for stall, reset mid-row and ignored starts.
module tb_check_node_message_generator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_row_generation;
    logic [31:0] min_in;
    logic [31:0] second_min_in;
    logic [1:0]  pos_in;
    logic [2:0]  sign_in;
    logic        msg_ready;
    logic        msg_valid;
    logic [31:0] msg_out;
    logic [1:0]  msg_index;
    logic        busy;
    logic        done_row_generation;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0]      mn;
        logic [31:0]      smn;
        logic [1:0]       pos;
        logic [2:0]       sgn;
        logic [2:0][31:0] exp_msg;
    } vec_t;

    typedef struct {
        logic [1:0]  idx;
        logic [31:0] msg;
    } sb_t;

    vec_t vecs[6];
    sb_t  sbq[$];

    check_node_message_generator #(
        .DEGREE(3),
        .WIDTH (32),
        .IDXW  (2)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start_row_generation(start_row_generation),
        .min_in              (min_in),
        .second_min_in       (second_min_in),
        .pos_in              (pos_in),
        .sign_in             (sign_in),
        .msg_ready           (msg_ready),
        .msg_valid           (msg_valid),
        .msg_out             (msg_out),
        .msg_index           (msg_index),
        .busy                (busy),
        .done_row_generation (done_row_generation)
    );

    always #5 clk = ~clk;

    function automatic vec_t mkvec(input logic [31:0] mn, input logic [31:0] smn,
                                   input logic [1:0] pos, input logic [2:0] sgn,
                                   input logic [31:0] e0, input logic [31:0] e1,
                                   input logic [31:0] e2);
        vec_t v;
        v.mn = mn;
        v.smn = smn;
        v.pos = pos;
        v.sgn = sgn;
        v.exp_msg[0] = e0;
        v.exp_msg[1] = e1;
        v.exp_msg[2] = e2;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one row, optionally stalling at an edge index, poking start while
    // busy or in the done cycle; scoreboard checks every accepted message.
    task automatic run_row(input vec_t v, input int stall_idx, input int stall_len,
                           input bit poke_busy, input bit poke_done);
        int  k;
        int  hs;
        int  dones;
        int  stalled;
        int  done_at;
        bit  fin;
        sb_t e;
        hs = 0;
        dones = 0;
        stalled = 0;
        done_at = -1;
        fin = 1'b0;
        for (int j = 0; j < 3; j++) begin
            e.idx = 2'(j);
            e.msg = v.exp_msg[j];
            sbq.push_back(e);
        end
        min_in = v.mn;
        second_min_in = v.smn;
        pos_in = v.pos;
        sign_in = v.sgn;
        msg_ready = 1'b0;
        start_row_generation = 1'b1;
        step();
        start_row_generation = 1'b0;
        // Captured values must not follow the inputs after this point.
        min_in = $urandom;
        second_min_in = $urandom;
        pos_in = 2'($urandom);
        sign_in = 3'($urandom);
        k = 1;
        while (!fin && k < 20 + stall_len) begin
            start_row_generation = 1'b0;
            if (poke_busy && k == 2) begin
                start_row_generation = 1'b1;
                min_in = 32'h3F800000;
            end
            if (msg_valid && msg_index == 2'(stall_idx) && stalled < stall_len) begin
                msg_ready = 1'b0;
                stalled++;
                if (sbq.size() > 0) begin
                    check("stall_msg", msg_out, sbq[0].msg);
                    check("stall_idx", 32'(msg_index), 32'(sbq[0].idx));
                end
            end else begin
                msg_ready = 1'b1;
            end
            if (msg_valid && msg_ready) begin
                hs++;
                if (sbq.size() == 0) begin
                    check("sb_empty", 32'(msg_valid), 32'd0);
                end else begin
                    e = sbq.pop_front();
                    check("msg_idx", 32'(msg_index), 32'(e.idx));
                    check("msg_out", msg_out, e.msg);
                end
            end
            if (done_row_generation) begin
                dones++;
                done_at = k;
                fin = 1'b1;
                check("done_valid", 32'(msg_valid), 32'd0);
                check("done_busy", 32'(busy), 32'd1);
                if (poke_done) start_row_generation = 1'b1;
            end
            step();
            k++;
        end
        start_row_generation = 1'b0;
        msg_ready = 1'b0;
        check("row_finished", 32'(fin), 32'd1);
        check("handshakes", 32'(hs), 32'd3);
        check("done_pulses", 32'(dones), 32'd1);
        check("latency", 32'(done_at), 32'(4 + stall_len));
        check("post_done", 32'(done_row_generation), 32'd0);
        check("post_busy", 32'(busy), 32'd0);
        check("post_valid", 32'(msg_valid), 32'd0);
        if (poke_done) begin
            step();
            check("done_start_ignored", 32'(msg_valid), 32'd0);
        end
        sbq.delete();
    endtask

    initial begin
        // T1, T2, T6 zero-magnitude, T6 pos out of range, all-negative with
        // sign bit set on min_in, mixed signs with pos=0.
        vecs[0] = mkvec(32'h3E999999, 32'h3F99999A, 2'd1, 3'b000,
                        32'h3E999999, 32'h3F99999A, 32'h3E999999);
        vecs[1] = mkvec(32'h3E999999, 32'h3F99999A, 2'd1, 3'b001,
                        32'h3E999999, 32'hBF99999A, 32'hBE999999);
        vecs[2] = mkvec(32'h00000000, 32'h3F99999A, 2'd0, 3'b010,
                        32'hBF99999A, 32'h00000000, 32'h00000000);
        vecs[3] = mkvec(32'h3E999999, 32'h3F99999A, 2'd3, 3'b010,
                        32'hBE999999, 32'h3E999999, 32'hBE999999);
        vecs[4] = mkvec(32'hC0000000, 32'h40400000, 2'd2, 3'b111,
                        32'h40000000, 32'h40000000, 32'h40400000);
        vecs[5] = mkvec(32'h3F800000, 32'h40000000, 2'd0, 3'b110,
                        32'h40000000, 32'hBF800000, 32'hBF800000);

        rst = 1'b1;
        start_row_generation = 1'b0;
        min_in = '0;
        second_min_in = '0;
        pos_in = '0;
        sign_in = '0;
        msg_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst_valid", 32'(msg_valid), 32'd0);
        check("rst_msg", msg_out, 32'd0);
        check("rst_idx", 32'(msg_index), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done_row_generation), 32'd0);

        for (int i = 0; i < 6; i++) begin
            run_row(vecs[i], -1, 0, 1'b0, 1'b0);
            step();
        end

        // Backpressure: four stalled cycles at edge 1.
        run_row(vecs[0], 1, 4, 1'b0, 1'b0);
        step();

        // Start while busy with a different min is ignored; start in DONE ignored.
        run_row(vecs[0], -1, 0, 1'b1, 1'b1);
        step();

        // Reset mid-row at edge 1.
        min_in = vecs[0].mn;
        second_min_in = vecs[0].smn;
        pos_in = vecs[0].pos;
        sign_in = vecs[0].sgn;
        start_row_generation = 1'b1;
        msg_ready = 1'b1;
        step();
        start_row_generation = 1'b0;
        step();
        check("pre_rst_idx", 32'(msg_index), 32'd1);
        rst = 1'b1;
        msg_ready = 1'b0;
        step();
        rst = 1'b0;
        check("mid_rst_valid", 32'(msg_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("mid_rst_no_done", 32'(done_row_generation), 32'd0);
            step();
        end
        run_row(vecs[1], -1, 0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
